seg7_display_capture: RTL and testbench
=======================================

Name: seg7_display_capture

Overview:
- Reads back the four 7-segment digit buses driven by the counter/display block and recovers the 16-bit hex value shown.
- Filters glyph transitions: a value is published only after it has been stable for a programmable number of sample ticks.
- Flags illegal or mode-inconsistent glyphs.
- Used on-chip for readback/LED mirroring and in benches as a self-checking display monitor.

Parameters:
- p_sample_div, 25: clocks per sample tick; legal range 1..65535.
- p_stable_cycles, 4: consecutive identical samples required before publishing; legal range 1..15.

Ports:
- i_clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- seven_Display1  in  7  digit 0 (least significant nibble), segments active-low, bit0=a … bit6=g.
- seven_Display2  in  7  digit 1.
- seven_Display3  in  7  digit 2.
- seven_Display4  in  7  digit 3 (most significant nibble).
- i_dec_mode  in  1  1 = decimal display expected; glyphs A–F are illegal.
- o_value  out  16  last published value; digit n maps to o_value[4n+3:4n].
- o_blank  out  4  per-digit blank mask of the published value.
- o_valid  out  1  published value matches the current stable display.
- o_change  out  1  one-cycle pulse when a newly published value or blank mask differs from the previous one.
- o_error  out  1  last stable pattern contained an illegal glyph.
- o_err_digit  out  4  per-digit illegal-glyph mask of the last stable pattern.

Behaviour:
- Glyph table (active-low hex):
  - Digits 0–7: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - Digits 8–F: 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - Blank: 7F, decodes as nibble 0 with the blank bit set.
  - Any other pattern is illegal. A–F are also illegal when i_dec_mode=1.
- Reset, synchronous, takes priority over everything:
  - o_value=0, o_blank=4'hF, o_valid=0, o_change=0, o_error=0, o_err_digit=0.
  - Divider=0, stable count=0, state=IDLE, first-sample flag set.
- Divider:
  - Counts 0..p_sample_div-1.
  - A tick occurs in the cycle the count equals p_sample_div-1; the count then wraps to 0.
  - With p_sample_div=1, every cycle is a tick.
- Sampling:
  - On a tick, the 28-bit concatenation {Display4..Display1} is registered as the current sample.
  - The current sample is compared with the previous sample.
- Stable counter (4 bits):
  - On a tick with the first-sample flag set, or with a sample different from the previous one, count=1.
  - On a tick with an equal sample, count increments, saturating at p_stable_cycles.
- State machine:
  - IDLE: the first tick goes to SETTLE.
  - SETTLE: when the count reaches p_stable_cycles on a tick, go to PUBLISH.
  - PUBLISH: a single cycle, then LOCKED.
  - LOCKED: a tick with a differing sample goes to SETTLE and clears o_valid in the next cycle. o_value and o_blank hold their last values.
  - If p_stable_cycles=1, every new pattern publishes at its first tick.
- PUBLISH cycle, i.e. the cycle after the qualifying tick. Outputs are registered and visible the following cycle:
  - No illegal digits: o_value and o_blank load the decoded pattern; o_valid=1, o_error=0, o_err_digit=0.
  - o_change=1 for one cycle if the loaded value or blank differs from the previous published state. The first publish after reset always pulses.
  - Any illegal digit: o_value and o_blank hold; o_valid=0, o_error=1, o_err_digit = mask of illegal digits; no o_change pulse.
- i_dec_mode changes:
  - Sampled at PUBLISH only; not retroactive.
  - A change while LOCKED takes effect at the next publish.
- Simultaneous events:
  - Reset asserted in the same cycle as a tick: reset wins.
  - Display change on the qualifying tick: the count restarts at 1 and there is no publish.
- Latency, from stable input to o_valid: at most (p_stable_cycles+1)·p_sample_div + 2 clocks.
- Throughput: at most one publish per p_sample_div·p_stable_cycles clocks after each change.

Test Plan:
- Reset, then drive "0b78" (Display4..1 = 40,03,78,00), defaults:
  - The first tick occurs 25 clocks after reset deasserts.
  - o_valid rises 2 cycles after the 4th tick with o_value=16'h0B78, o_blank=0.
  - o_change pulses once.
- Same value held 1000 clocks: o_valid stays 1, no further o_change.
- Change Display1 to 79 for 2 ticks, then back to 00:
  - o_valid drops 1 cycle after the first differing tick.
  - o_value stays 0B78 throughout.
  - Republish of 0B78 occurs with no o_change pulse.
- Display2 = 5A (illegal), held 4 ticks: o_error=1, o_err_digit=4'b0010, o_valid=0, o_value unchanged.
- i_dec_mode=1 with "00A5" stable: o_error=1, o_err_digit=4'b0010. Then drive "0095": o_error=0, o_value=16'h0095, o_change=1.
- Assert reset for 1 cycle while in SETTLE: all outputs return to reset values and publishing restarts from IDLE.
- Blank display (7F ×4): o_value=0, o_blank=4'hF. This matches the reset state, so no o_change except as the first publish after reset.

Source files
------------

// File: rtl/seg7_display_capture.sv
// seg7_display_capture: recovers the 16-bit hex value shown on four active-low 7-segment digits, publishing only stable glyphs
// Ports: i_clk/reset (sync, active-high); seven_Display1..4 digit 0..3 segments (bit0=a..bit6=g);
// i_dec_mode rejects A-F; o_value/o_blank published value and blank mask; o_valid published==stable display;
// o_change one-cycle pulse on a new published value; o_error/o_err_digit illegal glyphs in last stable pattern.
module seg7_display_capture #(
  parameter int p_sample_div = 25,
  parameter int p_stable_cycles = 4
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic [6:0]  seven_Display1,
  input  logic [6:0]  seven_Display2,
  input  logic [6:0]  seven_Display3,
  input  logic [6:0]  seven_Display4,
  input  logic        i_dec_mode,
  output logic [15:0] o_value,
  output logic [3:0]  o_blank,
  output logic        o_valid,
  output logic        o_change,
  output logic        o_error,
  output logic [3:0]  o_err_digit
);
  typedef enum logic [1:0] {IDLE, SETTLE, PUBLISH, LOCKED} state_t;
  localparam logic [15:0] div_last = 16'(p_sample_div - 1);
  localparam logic [3:0] stable = 4'(p_stable_cycles);
  state_t st;
  logic [15:0] div;
  logic [27:0] smp;
  logic [3:0] cnt;
  logic first;
  logic fresh;
  logic [27:0] din;
  logic tick;
  logic diff;
  logic qual;
  logic [3:0] cnt_n;
  logic [15:0] dec_val;
  logic [3:0] dec_blank;
  logic [3:0] dec_ill;
  // {illegal, blank, nibble}
  function automatic logic [5:0] decode(input logic [6:0] g, input logic dm);
    logic [5:0] r;
    case (g)
      7'h40: r = 6'h00;
      7'h79: r = 6'h01;
      7'h24: r = 6'h02;
      7'h30: r = 6'h03;
      7'h19: r = 6'h04;
      7'h12: r = 6'h05;
      7'h02: r = 6'h06;
      7'h78: r = 6'h07;
      7'h00: r = 6'h08;
      7'h10: r = 6'h09;
      7'h08: r = 6'h0A;
      7'h03: r = 6'h0B;
      7'h46: r = 6'h0C;
      7'h21: r = 6'h0D;
      7'h06: r = 6'h0E;
      7'h0E: r = 6'h0F;
      7'h7F: r = 6'h10;
      default: r = 6'h20;
    endcase
    return {r[5] | (dm & (r[3:0] > 4'd9)), r[4:0]};
  endfunction
  assign din = {seven_Display4, seven_Display3, seven_Display2, seven_Display1};
  assign tick = div == div_last;
  assign diff = first || din != smp;
  assign cnt_n = diff ? 4'd1 : (cnt >= stable ? stable : cnt + 4'd1);
  assign qual = cnt_n == stable;
  for (genvar g = 0; g < 4; g++) begin : g_dec
    assign {dec_ill[g], dec_blank[g], dec_val[4*g +: 4]} = decode(smp[7*g +: 7], i_dec_mode);
  end
  always_ff @(posedge i_clk) begin
    if (reset) begin
      st <= IDLE;
      div <= '0;
      smp <= '0;
      cnt <= '0;
      first <= 1'b1;
      fresh <= 1'b1;
      o_value <= '0;
      o_blank <= 4'hF;
      o_valid <= 1'b0;
      o_change <= 1'b0;
      o_error <= 1'b0;
      o_err_digit <= '0;
    end else begin
      div <= tick ? '0 : div + 16'd1;
      o_change <= 1'b0;
      if (tick) begin
        smp <= din;
        cnt <= cnt_n;
        first <= 1'b0;
      end
      case (st)
        IDLE: if (tick) st <= qual ? PUBLISH : SETTLE;
        SETTLE: if (tick && qual) st <= PUBLISH;
        PUBLISH: begin
          // a differing tick landing on the publish cycle itself restarts settling
          st <= (tick && diff) ? (qual ? PUBLISH : SETTLE) : LOCKED;
          if (|dec_ill) begin
            o_valid <= 1'b0;
            o_error <= 1'b1;
            o_err_digit <= dec_ill;
          end else begin
            o_value <= dec_val;
            o_blank <= dec_blank;
            o_valid <= !(tick && diff);
            o_error <= 1'b0;
            o_err_digit <= '0;
            o_change <= fresh || dec_val != o_value || dec_blank != o_blank;
            fresh <= 1'b0;
          end
        end
        LOCKED: if (tick && diff) begin
          st <= qual ? PUBLISH : SETTLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seg7_display_capture.sv
// tb_seg7_display_capture: scoreboard bench for seg7_display_capture with default timing
module tb_seg7_display_capture;
  logic i_clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] seven_Display1, seven_Display2, seven_Display3, seven_Display4;
  logic i_dec_mode = 1'b0;
  logic [15:0] o_value;
  logic [3:0] o_blank;
  logic o_valid, o_change, o_error;
  logic [3:0] o_err_digit;
  typedef struct {
    logic [15:0] v;
    logic [3:0] b;
    logic va;
    logic er;
    logic [3:0] ed;
    logic ch;
  } exp_t;
  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic pv = 1'b0;
  logic pe = 1'b0;
  seg7_display_capture #(.p_sample_div(25), .p_stable_cycles(4)) dut (
    .i_clk(i_clk),
    .reset(reset),
    .seven_Display1(seven_Display1),
    .seven_Display2(seven_Display2),
    .seven_Display3(seven_Display3),
    .seven_Display4(seven_Display4),
    .i_dec_mode(i_dec_mode),
    .o_value(o_value),
    .o_blank(o_blank),
    .o_valid(o_valid),
    .o_change(o_change),
    .o_error(o_error),
    .o_err_digit(o_err_digit)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic show(input logic [6:0] d4, input logic [6:0] d3, input logic [6:0] d2, input logic [6:0] d1);
    seven_Display4 = d4;
    seven_Display3 = d3;
    seven_Display2 = d2;
    seven_Display1 = d1;
  endtask
  task automatic expect_pub(input logic [15:0] v, input logic [3:0] b, input logic va, input logic er,
                            input logic [3:0] ed, input logic ch);
    exp_t e;
    e.v = v;
    e.b = b;
    e.va = va;
    e.er = er;
    e.ed = ed;
    e.ch = ch;
    q.push_back(e);
  endtask
  task automatic check_reset_outputs(input string p);
    check({p, "_value"}, o_value, 0);
    check({p, "_blank"}, o_blank, 4'hF);
    check({p, "_valid"}, o_valid, 0);
    check({p, "_change"}, o_change, 0);
    check({p, "_error"}, o_error, 0);
    check({p, "_err_digit"}, o_err_digit, 0);
  endtask
  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge i_clk);
      #2;
      if (cyc > 0 && cyc % 25 == 0) k++;
    end
  endtask
  task automatic drain(input string tag);
    int k = 0;
    while (q.size() != 0 && k < 400) begin
      @(posedge i_clk);
      #2;
      k++;
    end
    check({tag, "_pending"}, q.size(), 0);
  endtask
  // monitor: cycle counter since reset plus publish-event scoreboard
  initial begin
    logic r;
    logic ev;
    exp_t e;
    forever begin
      @(posedge i_clk);
      r = reset;
      #1;
      cyc = r ? 0 : cyc + 1;
      ev = (o_valid && !pv) || (o_error && !pe);
      pv = o_valid;
      pe = o_error;
      if (ev) begin
        if (q.size() == 0) check("unexpected_publish", 1, 0);
        else begin
          e = q.pop_front();
          check("pub_value", o_value, e.v);
          check("pub_blank", o_blank, e.b);
          check("pub_valid", o_valid, e.va);
          check("pub_error", o_error, e.er);
          check("pub_err_digit", o_err_digit, e.ed);
          check("pub_change", o_change, e.ch);
        end
      end
    end
  end
  initial begin
    int lat;
    int nch;
    int nlow;
    show(7'h40, 7'h03, 7'h78, 7'h00);
    reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #2;
    reset = 1'b0;
    check_reset_outputs("rst");
    expect_pub(16'h0B78, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
    lat = -1;
    for (int k = 0; k < 300 && lat < 0; k++) begin
      @(posedge i_clk);
      #2;
      if (o_valid) lat = cyc;
    end
    check("first_valid_latency", lat, 101);
    nch = 0;
    nlow = 0;
    repeat (1000) begin
      @(posedge i_clk);
      #2;
      nch += int'(o_change);
      nlow += int'(!o_valid);
    end
    check("hold_change_pulses", nch, 0);
    check("hold_valid_lows", nlow, 0);
    wait_ticks(1);
    seven_Display1 = 7'h79;
    wait_ticks(1);
    check("glitch_valid_drop", o_valid, 0);
    check("glitch_value_hold", o_value, 16'h0B78);
    wait_ticks(1);
    check("glitch_value_hold2", o_value, 16'h0B78);
    seven_Display1 = 7'h00;
    expect_pub(16'h0B78, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);
    drain("republish");
    seven_Display2 = 7'h5A;
    expect_pub(16'h0B78, 4'h0, 1'b0, 1'b1, 4'b0010, 1'b0);
    drain("illegal");
    seven_Display2 = 7'h78;
    expect_pub(16'h0B78, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);
    drain("recover");
    i_dec_mode = 1'b1;
    show(7'h40, 7'h40, 7'h08, 7'h12);
    expect_pub(16'h0B78, 4'h0, 1'b0, 1'b1, 4'b0010, 1'b0);
    drain("dec_illegal");
    show(7'h40, 7'h40, 7'h10, 7'h12);
    expect_pub(16'h0095, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
    drain("dec_legal");
    show(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    wait_ticks(2);
    check("settle_valid", o_valid, 0);
    check("settle_value", o_value, 16'h0095);
    reset = 1'b1;
    @(posedge i_clk);
    #2;
    reset = 1'b0;
    check_reset_outputs("rst2");
    expect_pub(16'h0000, 4'hF, 1'b1, 1'b0, 4'h0, 1'b1);
    drain("blank");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
